// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM states, frame sizing, parity mode.
// Also holds the parity-check helper used by the receive controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE
  } state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_mode_t;

  localparam int FRAME_BITS = 11;
  // start, parity and stop wrap the data bits
  localparam int DATA_BITS  = FRAME_BITS - 3;

  function automatic logic par_err(
    input logic [DATA_BITS-1:0] d,
    input logic                 p,
    input par_mode_t            m
  );
    return (^d ^ p) != logic'(m);
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-byte valid/ready interface with error status.
// Master is the receive controller, slave is the byte consumer.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;

  modport master (
    output rx_data, rx_valid,
    output parity_err, frame_err, overrun_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid,
    input  parity_err, frame_err, overrun_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Serial-line synchronizer, per-bit tick counter and 3-sample vote.
// tcnt is held at 0 whenever run is low so each frame starts aligned.
module uart_rx_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int MID        = OVERSAMPLE / 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic baud_tick,
  input  logic rx_serial,
  input  logic run,
  output logic rxs,
  output logic bit_tick,
  output logic bit_end,
  output logic vote
);

  localparam int TW = $clog2(OVERSAMPLE);

  logic [1:0]    sync;
  logic [TW-1:0] tcnt;
  logic [1:0]    smp;

  assign rxs      = sync[1];
  assign bit_tick = run & baud_tick
                  & (tcnt == TW'(MID + 1));
  assign bit_end  = run & baud_tick
                  & (tcnt == TW'(OVERSAMPLE - 1));
  // third sample is the live value on the decision tick
  assign vote     = (smp[0] & smp[1])
                  | (smp[0] & rxs)
                  | (smp[1] & rxs);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= 2'b11;
      tcnt <= '0;
      smp  <= 2'b11;
    end else begin
      sync <= {sync[0], rx_serial};
      if (!run) begin
        tcnt <= '0;
      end else if (baud_tick) begin
        tcnt <= bit_end ? '0 : tcnt + 1'b1;
        if (tcnt == TW'(MID - 1)) smp[0] <= rxs;
        if (tcnt == TW'(MID))     smp[1] <= rxs;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start validation, SIPO shift pulses,
// deframer qualify, field checks and a holding register with overrun.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int MID        = OVERSAMPLE / 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  input  logic                 parity_odd,
  output logic                 sipo_shift,
  output logic                 sipo_bit,
  output logic                 frame_valid,
  input  logic [DATA_BITS-1:0] df_data,
  input  logic                 df_parity,
  input  logic                 df_stop,
  output logic                 busy,
  uart_rx_ctrl_if.master       rx
);

  state_t     state, state_nx;
  logic [3:0] bcnt, bcnt_nx;
  logic       armed, armed_nx;
  logic       podd, podd_nx;
  logic       rxs, bit_tick, bit_end, vote;
  logic       run, perr, ferr;

  assign run  = (state != IDLE) && (state != DONE);
  assign busy = (state != IDLE);
  assign perr = par_err(df_data, df_parity, par_mode_t'(podd));
  assign ferr = ~df_stop;

  uart_rx_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .MID        (MID)
  ) u_sampler (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .rx_serial (rx_serial),
    .run       (run),
    .rxs       (rxs),
    .bit_tick  (bit_tick),
    .bit_end   (bit_end),
    .vote      (vote)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      bcnt  <= '0;
      armed <= 1'b0;
      podd  <= 1'b0;
    end else begin
      state <= state_nx;
      bcnt  <= bcnt_nx;
      armed <= armed_nx;
      podd  <= podd_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bcnt_nx     = bcnt;
    armed_nx    = armed;
    podd_nx     = podd;
    sipo_shift  = 1'b0;
    sipo_bit    = 1'b1;
    frame_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (baud_tick && rxs) armed_nx = 1'b1;
        if (baud_tick && armed && !rxs) begin
          state_nx = START;
          armed_nx = 1'b0;
        end
      end
      START: begin
        if (bit_tick && vote) begin
          state_nx = IDLE;
        end else begin
          if (bit_tick) begin
            sipo_shift = 1'b1;
            sipo_bit   = 1'b0;
            podd_nx    = parity_odd;
          end
          if (bit_end) begin
            state_nx = DATA;
            bcnt_nx  = '0;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          sipo_shift = 1'b1;
          sipo_bit   = vote;
          bcnt_nx    = bcnt + 4'd1;
        end
        if (bit_end && bcnt == 4'(DATA_BITS))
          state_nx = PARITY;
      end
      PARITY: begin
        if (bit_tick) begin
          sipo_shift = 1'b1;
          sipo_bit   = vote;
        end
        if (bit_end) state_nx = STOP;
      end
      STOP: begin
        if (bit_tick) begin
          sipo_shift = 1'b1;
          sipo_bit   = vote;
          state_nx   = DONE;
        end
      end
      DONE: begin
        frame_valid = 1'b1;
        state_nx    = IDLE;
        // a low line after the frame is a break; wait for high
        armed_nx    = rxs;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx.rx_data     <= '0;
      rx.rx_valid    <= 1'b0;
      rx.parity_err  <= 1'b0;
      rx.frame_err   <= 1'b0;
      rx.overrun_err <= 1'b0;
    end else begin
      rx.overrun_err <= 1'b0;
      if (frame_valid) begin
        if (!rx.rx_valid || rx.rx_ready) begin
          rx.rx_data    <= df_data;
          rx.parity_err <= perr;
          rx.frame_err  <= ferr;
          rx.rx_valid   <= 1'b1;
        end else begin
          rx.overrun_err <= 1'b1;
        end
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART datapath.
- Oversamples the synchronized serial line and detects and validates the start bit.
- Pulses the SIPO shift-enable once per bit for the 11-bit frame: start, 8 data LSB-first, parity, stop.
- Raises the deframer's frame-valid qualifier, checks the returned fields, and presents the byte plus error status on a valid/ready interface with overrun detection.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit; even, ≥8.
- MID, OVERSAMPLE/2, tick index of the centre sample; votes use MID-1, MID, MID+1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- baud_tick  in  1  one-clk enable at OVERSAMPLE × baud rate
- rx_serial  in  1  asynchronous serial line, idle high
- parity_odd  in  1  0 = even parity, 1 = odd; sampled at start-bit validation
- sipo_shift  out  1  one-clk pulse: shift sipo_bit into SIPO
- sipo_bit  out  1  majority-voted bit value, valid with sipo_shift
- frame_valid  out  1  deframer qualifier, high exactly one clk per completed frame
- df_data  in  8  deframed data byte (combinational return)
- df_parity  in  1  deframed parity bit
- df_stop  in  1  deframed stop bit
- rx_data  out  8  held received byte
- rx_valid  out  1  rx_data/error flags valid
- rx_ready  in  1  consumer accept
- parity_err  out  1  parity mismatch for held byte
- frame_err  out  1  stop bit = 0 for held byte
- overrun_err  out  1  one-clk pulse: frame dropped because the holding register was full
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_n=0 at clk edge), from any state including mid-frame:
  - state IDLE, all counters 0.
  - sipo_shift=0, sipo_bit=1, frame_valid=0, rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, busy=0.
  - armed=0; synchronizer flops preset to 1.
- Input: 2-flop synchronizer on rx_serial. All logic uses rxs, the synchronized value.
- Arming: armed sets when rxs=1 is sampled on a baud_tick in IDLE. It clears on entering START. A line held low never re-triggers.
- Tick counter tcnt counts 0..OVERSAMPLE-1, advancing only on baud_tick, and wraps to 0 at each bit boundary.
- Majority vote: rxs is captured at tcnt = MID-1, MID, MID+1. The voted bit is 2-of-3. The decision is taken on the baud_tick at tcnt = MID+1.
- States:
  - IDLE: on baud_tick with armed=1 and rxs=0, go to START with tcnt=0.
  - START: at the decision tick:
    - vote=1: false start, return to IDLE; no shift, armed stays clear.
    - vote=0: pulse sipo_shift with sipo_bit=0, latch parity_odd.
    - At tcnt wrap, go to DATA with bcnt=0.
  - DATA: at each decision tick, pulse sipo_shift with the voted bit and increment bcnt. At the wrap after bcnt reaches 8, go to PARITY.
  - PARITY: at the decision tick, pulse sipo_shift. At wrap, go to STOP.
  - STOP: at the decision tick, pulse sipo_shift, then go to DONE on the next clk. There is no wait for the end of the stop bit, so back-to-back frames are supported.
  - DONE: one clk.
    - frame_valid=1; df_* are sampled in this same clk.
    - Next state IDLE. armed is set only if rxs=1; otherwise wait for line high.
- Checks in DONE:
  - perr = (^df_data ^ df_parity) != parity_odd_latched.
  - ferr = ~df_stop.
- Holding register, evaluated in the DONE clk:
  - rx_valid=0, or rx_valid=1 and rx_ready=1 (consume and load in the same clk): load rx_data, parity_err, frame_err; rx_valid=1. No overrun.
  - rx_valid=1 and rx_ready=0: keep the old byte and flags; overrun_err=1 for one clk.
- Handshake outside DONE: rx_valid & rx_ready clears rx_valid next clk. rx_data and the flags hold their values until the next load.
- Exactly 11 sipo_shift pulses per accepted frame; 0 pulses for a false start.
- frame_valid is never asserted without 11 preceding shifts.
- Break condition: a line held low gives data 0x00 and ferr=1. The frame is delivered with frame_err=1; a new start is detected only after rxs returns high.
- baud_tick deasserted: the FSM holds its state. Only DONE and the handshake logic advance on clk alone.

Decomposition:
- Shared uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, DONE.
  - constants FRAME_BITS=11, DATA_BITS=8.
  - parity-mode encoding.
- Sub-module uart_rx_sampler: synchronizer, tcnt, 3-sample majority vote. Outputs rxs, bit_tick (the decision tick), bit_end (wrap) and vote.
- The FSM, holding register and checks stay in uart_rx_ctrl.

Test Plan:
- Even parity, frame 0xA5 (parity 0, stop 1), rx_ready=1 → 11 sipo_shift pulses with bits 0,1,0,1,0,0,1,0,1,0,1, then frame_valid for 1 clk, rx_data=0xA5, rx_valid=1, both error flags 0.
- parity_odd=1, 0x3C sent with parity 0 → parity_err=1, rx_data=0x3C, frame_err=0.
- rx low for 4 ticks, then high → START aborts at the decision tick, 0 shifts, no frame_valid, busy returns to 0.
- Two back-to-back frames 0x11 then 0x22 with rx_ready=0 → rx_data stays 0x11, overrun_err pulses once at the second DONE. Then with rx_ready=1 in the second DONE clk instead → rx_data=0x22, no overrun.
- Line low for 12 bit times → one frame, rx_data=0x00, frame_err=1. No second frame until rx_serial goes high, then a valid frame 0x5A is received normally.
- reset_n=0 for 1 clk during DATA bit 4 → next clk IDLE, rx_valid=0, no frame_valid. A subsequent 0xFF frame is received correctly.
